i2s_receiver: RTL and testbench

Capture side of the WM8731 audio link. It recovers stereo sample pairs from the codec ADC serial stream (AUD_ADCDAT), framed by the BCK/LRCK that our `i2s` transmitter already drives. It runs in the `clock` domain and oversamples BCK, LRCK and DAT. It delivers one left/right frame at a time on a valid/ready handshake for downstream DSP or loopback.

---
 rtl/i2s_receiver.sv | 137 +++++++++++++
 tb/tb_i2s_receiver.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S capture for the WM8731 ADC stream: oversamples BCK/LRCK/DAT in the system
// clock domain and hands out complete left/right frames on a valid/ready handshake.
module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bck,
  input  logic                  lrck,
  input  logic                  dat,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  output logic                  frame_error
);

  localparam logic [CNT_WIDTH-1:0] LP_DW    = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LP_DW_M1 = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_WAIT_EDGE, ST_RECEIVE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_bck_sync;
  logic [1:0]            r_lrck_sync;
  logic [1:0]            r_dat_sync;
  logic                  r_bck_prev;
  logic                  r_lrck_last;
  logic                  r_channel;
  logic [CNT_WIDTH-1:0]  r_bitcnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_hold_left;
  logic                  r_left_present;

  logic                  w_rise;
  logic                  w_lrck_s;
  logic                  w_dat_s;
  logic                  w_lr_change;
  logic                  w_slot_start;
  logic                  w_shift_en;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_done;
  logic                  w_frame_done;
  logic                  w_slot_err;
  logic                  w_load;

  always_comb begin
    w_rise       = r_bck_sync[1] & ~r_bck_prev;
    w_lrck_s     = r_lrck_sync[1];
    w_dat_s      = r_dat_sync[1];
    w_lr_change  = (w_lrck_s != r_lrck_last);
    w_slot_start = w_rise && w_lr_change && (r_state != ST_SYNC);
    w_shift_en   = w_rise && (r_state == ST_RECEIVE) && !w_lr_change && (r_bitcnt < LP_DW);
    w_word       = DATA_WIDTH'({r_shift, w_dat_s});
    w_word_done  = w_shift_en && (r_bitcnt == LP_DW_M1);
    // A frame is only complete when a right word lands on top of a held left word.
    w_frame_done = w_word_done && r_channel && r_left_present;
    w_slot_err   = w_rise && (r_state == ST_RECEIVE) && w_lr_change && (r_bitcnt < LP_DW);
    w_load       = w_frame_done && (!frame_valid || frame_ready);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SYNC:      if (w_rise) w_state_nxt = ST_WAIT_EDGE;
      ST_WAIT_EDGE: if (w_slot_start) w_state_nxt = ST_RECEIVE;
      ST_RECEIVE:   w_state_nxt = ST_RECEIVE;
      default:      w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_SYNC;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bck_sync     <= '0;
      r_lrck_sync    <= '0;
      r_dat_sync     <= '0;
      r_bck_prev     <= 1'b0;
      r_lrck_last    <= 1'b0;
      r_channel      <= 1'b0;
      r_bitcnt       <= '0;
      r_shift        <= '0;
      r_hold_left    <= '0;
      r_left_present <= 1'b0;
      left_data      <= '0;
      right_data     <= '0;
      frame_valid    <= 1'b0;
      overrun        <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      r_bck_sync  <= {r_bck_sync[0], bck};
      r_lrck_sync <= {r_lrck_sync[0], lrck};
      r_dat_sync  <= {r_dat_sync[0], dat};
      r_bck_prev  <= r_bck_sync[1];
      if (w_rise) r_lrck_last <= w_lrck_s;

      // The bit on the slot-start rise is the I2S one-bit delay and is not shifted in.
      if (w_slot_start) begin
        r_channel <= w_lrck_s;
        r_bitcnt  <= '0;
      end else if (w_shift_en) begin
        r_shift  <= w_word;
        r_bitcnt <= r_bitcnt + 1'b1;
      end

      if (w_slot_err && !r_channel) begin
        r_left_present <= 1'b0;
      end else if (w_word_done) begin
        if (!r_channel) begin
          r_hold_left    <= w_word;
          r_left_present <= 1'b1;
        end else begin
          r_left_present <= 1'b0;
        end
      end

      frame_error <= w_slot_err;
      overrun     <= w_frame_done && !w_load;

      if (w_load) begin
        left_data   <= r_hold_left;
        right_data  <= w_word;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: drives I2S slots from a slot-level model
// and compares delivered frames, error/overrun pulses and latency.
module tb_i2s_receiver;
  localparam int DW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          bck = 1'b0;
  logic          lrck = 1'b0;
  logic          dat = 1'b0;
  logic          frame_ready = 1'b1;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          frame_valid;
  logic          overrun;
  logic          frame_error;

  i2s_receiver #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .clock(clock), .reset(reset), .bck(bck), .lrck(lrck), .dat(dat),
    .left_data(left_data), .right_data(right_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .overrun(overrun), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last = 0;
  int obs_err = 0, obs_ovr = 0, exp_err = 0, exp_ovr = 0;
  logic [DW-1:0] obs_l[$], obs_r[$], exp_l[$], exp_r[$];
  int lat_q[$];
  logic prev_valid = 1'b0;

  // snapshot of outputs taken one cycle into a mid-slot reset
  logic          snap_valid, snap_ovr, snap_err;
  logic [DW-1:0] snap_l, snap_r;

  // slot-level reference model state
  bit            m_sync = 0, m_rx = 0, m_prev_short = 0, m_prev_ch = 0, m_lp = 0, m_full = 0;
  logic [DW-1:0] m_left = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frame_valid && !prev_valid) begin
      obs_l.push_back(left_data);
      obs_r.push_back(right_data);
      lat_q.push_back(cyc - t_last);
    end
    prev_valid = frame_valid;
    if (frame_error) obs_err++;
    if (overrun) obs_ovr++;
  end

  task automatic drive_bit(input logic l, input logic d, input bit mark, input bit do_rst);
    int lo, hi;
    lo = $urandom_range(2, 3);
    hi = $urandom_range(1, 2);
    @(negedge clock);
    bck = 1'b0; lrck = l; dat = d;
    if (do_rst) begin
      reset = 1'b0;
      @(negedge clock);
      snap_valid = frame_valid; snap_l = left_data; snap_r = right_data;
      snap_ovr = overrun; snap_err = frame_error;
      reset = 1'b1;
      lo--;
    end
    repeat (lo) @(negedge clock);
    bck = 1'b1;
    if (mark) t_last = cyc;
    repeat (hi) @(negedge clock);
  endtask

  // Model: slot after a reset only synchronises; a slot is complete with >= DW data
  // bits after the delay bit; a short slot is reported when the next slot starts.
  task automatic model_slot(input logic ch, input int nbits, input logic [DW-1:0] w, input bit was_rst);
    if (was_rst) begin
      m_rx = 0; m_prev_short = 0; m_lp = 0; m_full = 0; m_sync = 1;
      return;
    end
    if (!m_sync) begin
      m_sync = 1;
      return;
    end
    if (m_rx && m_prev_short) begin
      exp_err++;
      if (!m_prev_ch) m_lp = 0;
    end
    m_rx = 1; m_prev_ch = ch; m_prev_short = (nbits - 1 < DW);
    if (!m_prev_short) begin
      if (!ch) begin
        m_lp = 1; m_left = w;
      end else begin
        if (m_lp) begin
          if (m_full) exp_ovr++;
          else begin
            exp_l.push_back(m_left); exp_r.push_back(w); m_full = !frame_ready;
          end
        end
        m_lp = 0;
      end
    end
  endtask

  task automatic send_slot(input logic ch, input int nbits, input logic [DW-1:0] w, input int rst_at);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      if (i >= 1 && i <= DW) d = w[DW-i];
      else d = 1'($urandom_range(0, 1));
      drive_bit(ch, d, ch && (i == DW), i == rst_at);
    end
    model_slot(ch, nbits, w, rst_at >= 0);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clock);
    checks += 5;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", frame_valid); end
    if (left_data !== '0) begin errors++; $display("FAIL rst_left: got %h expected 0", left_data); end
    if (right_data !== '0) begin errors++; $display("FAIL rst_right: got %h expected 0", right_data); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", frame_error); end
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_basic();
    send_slot(1'b1, 32, DW'($urandom), -1);
    send_slot(1'b0, 32, 24'h123456, -1);
    send_slot(1'b1, 32, 24'hABCDEF, -1);
    repeat (12) @(negedge clock);
    checks++;
    if (obs_l.size() != 1 || exp_l.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d expected 1 (model %0d)", obs_l.size(), exp_l.size());
    end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      checks++;
      if (obs_l[i] !== 24'h123456 || obs_r[i] !== 24'hABCDEF || obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) begin
        errors++; $display("FAIL basic_frame: got %h/%h expected 123456/abcdef", obs_l[i], obs_r[i]);
      end
    end
    for (int i = 0; i < lat_q.size(); i++) begin
      checks++;
      if (lat_q[i] < 1 || lat_q[i] > 4) begin errors++; $display("FAIL basic_latency: got %0d expected 1..4", lat_q[i]); end
    end
    obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  task automatic test_overrun();
    int ovr0;
    ovr0 = obs_ovr;
    frame_ready = 1'b0;
    send_slot(1'b0, 32, 24'h000001, -1);
    send_slot(1'b1, 32, 24'h000002, -1);
    send_slot(1'b0, 32, 24'h000003, -1);
    send_slot(1'b1, 32, 24'h000004, -1);
    repeat (12) @(negedge clock);
    checks += 5;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", frame_valid); end
    if (left_data !== 24'h000001) begin errors++; $display("FAIL ovr_left_held: got %h expected 000001", left_data); end
    if (right_data !== 24'h000002) begin errors++; $display("FAIL ovr_right_held: got %h expected 000002", right_data); end
    if (obs_ovr - ovr0 != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", obs_ovr - ovr0); end
    if (obs_ovr != exp_ovr) begin errors++; $display("FAIL ovr_model: got %0d expected %0d", obs_ovr, exp_ovr); end
    frame_ready = 1'b1;
    @(negedge clock);
    m_full = 0;
    checks++;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_release: got %b expected 0", frame_valid); end
    checks++;
    if (obs_l.size() != exp_l.size()) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", obs_l.size(), exp_l.size()); end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      checks++;
      if (obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) begin
        errors++; $display("FAIL ovr_frame%0d: got %h/%h expected %h/%h", i, obs_l[i], obs_r[i], exp_l[i], exp_r[i]);
      end
    end
    obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  task automatic test_frame_error();
    int err0;
    err0 = obs_err;
    send_slot(1'b0, 10, DW'($urandom), -1);
    send_slot(1'b1, 32, DW'($urandom), -1);
    send_slot(1'b0, 32, 24'h7FFFFF, -1);
    send_slot(1'b1, 32, 24'h800000, -1);
    repeat (12) @(negedge clock);
    checks += 3;
    if (obs_err - err0 != 1) begin errors++; $display("FAIL err_pulses: got %0d expected 1", obs_err - err0); end
    if (obs_err != exp_err) begin errors++; $display("FAIL err_model: got %0d expected %0d", obs_err, exp_err); end
    if (obs_l.size() != 1 || exp_l.size() != 1) begin
      errors++; $display("FAIL err_count: got %0d expected 1 (model %0d)", obs_l.size(), exp_l.size());
    end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      checks++;
      if (obs_l[i] !== 24'h7FFFFF || obs_r[i] !== 24'h800000 || obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) begin
        errors++; $display("FAIL err_frame: got %h/%h expected 7fffff/800000", obs_l[i], obs_r[i]);
      end
    end
    obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  task automatic test_reset_mid_right();
    logic [DW-1:0] wl, wr;
    wl = DW'($urandom); wr = DW'($urandom);
    send_slot(1'b0, 32, DW'($urandom), -1);
    send_slot(1'b1, 32, DW'($urandom), 10);
    checks += 3;
    if (snap_valid !== 1'b0) begin errors++; $display("FAIL rstr_valid: got %b expected 0", snap_valid); end
    if (snap_l !== '0 || snap_r !== '0) begin errors++; $display("FAIL rstr_data: got %h/%h expected 0/0", snap_l, snap_r); end
    if (snap_ovr !== 1'b0 || snap_err !== 1'b0) begin errors++; $display("FAIL rstr_flags: got %b%b expected 00", snap_ovr, snap_err); end
    send_slot(1'b0, 32, wl, -1);
    send_slot(1'b1, 32, wr, -1);
    repeat (12) @(negedge clock);
    checks++;
    if (obs_l.size() != 1 || exp_l.size() != 1) begin
      errors++; $display("FAIL rstr_count: got %0d expected 1 (model %0d)", obs_l.size(), exp_l.size());
    end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      checks++;
      if (obs_l[i] !== wl || obs_r[i] !== wr || obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) begin
        errors++; $display("FAIL rstr_frame: got %h/%h expected %h/%h", obs_l[i], obs_r[i], wl, wr);
      end
    end
    obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  task automatic test_reset_mid_left();
    send_slot(1'b0, 32, DW'($urandom), 8);
    checks += 2;
    if (snap_valid !== 1'b0) begin errors++; $display("FAIL rstl_valid: got %b expected 0", snap_valid); end
    if (snap_l !== '0 || snap_r !== '0) begin errors++; $display("FAIL rstl_data: got %h/%h expected 0/0", snap_l, snap_r); end
    send_slot(1'b1, 32, DW'($urandom), -1);
    for (int k = 0; k < 2; k++) begin
      send_slot(1'b0, 32, DW'($urandom), -1);
      send_slot(1'b1, 32, DW'($urandom), -1);
    end
    repeat (12) @(negedge clock);
    checks++;
    if (obs_l.size() != 2 || exp_l.size() != 2) begin
      errors++; $display("FAIL rstl_count: got %0d expected 2 (model %0d)", obs_l.size(), exp_l.size());
    end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      checks++;
      if (obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) begin
        errors++; $display("FAIL rstl_frame%0d: got %h/%h expected %h/%h", i, obs_l[i], obs_r[i], exp_l[i], exp_r[i]);
      end
    end
    obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  task automatic test_loopback();
    int err0, ovr0;
    err0 = obs_err; ovr0 = obs_ovr;
    for (int k = 0; k < 4; k++) begin
      send_slot(1'b0, 32, 24'h7FFFFF, -1);
      send_slot(1'b1, 32, 24'h7FFFFF, -1);
    end
    repeat (12) @(negedge clock);
    checks += 2;
    if (obs_err != err0 || obs_ovr != ovr0) begin
      errors++; $display("FAIL loop_flags: got err %0d ovr %0d expected 0 0", obs_err - err0, obs_ovr - ovr0);
    end
    if (obs_l.size() != 4) begin errors++; $display("FAIL loop_count: got %0d expected 4", obs_l.size()); end
    for (int i = 0; i < obs_l.size(); i++) begin
      checks++;
      if (obs_l[i] !== 24'h7FFFFF || obs_r[i] !== 24'h7FFFFF) begin
        errors++; $display("FAIL loop_frame%0d: got %h/%h expected 7fffff/7fffff", i, obs_l[i], obs_r[i]);
      end
    end
    obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  task automatic test_random();
    int nl, nr;
    for (int k = 0; k < 16; k++) begin
      nl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, DW)) : int'($urandom_range(DW + 1, 32));
      nr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, DW)) : int'($urandom_range(DW + 1, 32));
      send_slot(1'b0, nl, DW'($urandom), -1);
      send_slot(1'b1, nr, DW'($urandom), -1);
    end
    send_slot(1'b0, 32, DW'($urandom), -1);
    send_slot(1'b1, 32, DW'($urandom), -1);
    repeat (12) @(negedge clock);
    checks += 3;
    if (obs_err != exp_err) begin errors++; $display("FAIL rand_errors: got %0d expected %0d", obs_err, exp_err); end
    if (obs_ovr != exp_ovr) begin errors++; $display("FAIL rand_overruns: got %0d expected %0d", obs_ovr, exp_ovr); end
    if (obs_l.size() != exp_l.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs_l.size(), exp_l.size()); end
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      checks++;
      if (obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) begin
        errors++; $display("FAIL rand_frame%0d: got %h/%h expected %h/%h", i, obs_l[i], obs_r[i], exp_l[i], exp_r[i]);
      end
    end
    for (int i = 1; i < lat_q.size(); i++) begin
      checks++;
      if (lat_q[i] != lat_q[0]) begin errors++; $display("FAIL rand_latency%0d: got %0d expected %0d", i, lat_q[i], lat_q[0]); end
    end
    obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_error();
    test_reset_mid_right();
    test_reset_mid_left();
    test_loopback();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
